// File: rtl/text_tile_fetcher.sv
// Character-cell text buffer: host character stream in (cursor, CR/LF, wrap, clear),
// per-pixel cell lookup out for the glyph ROM with one cycle of latency.
module text_tile_fetcher #(
    parameter int          ACTIVE_H_PIXELS  = 1280,
    parameter int          ACTIVE_LINES     = 720,
    parameter int          HORIZONTAL_WIDTH = 1660,
    parameter int          VERTICAL_WIDTH   = 750,
    parameter int          NUM_CHAR         = 256,
    parameter int          CHAR_W           = 8,
    parameter int          CHAR_H           = 16,
    parameter int unsigned BLANK_CHAR       = 32'h20,
    localparam int         CW               = $clog2(NUM_CHAR),
    localparam int         SXW              = $clog2(HORIZONTAL_WIDTH),
    localparam int         SYW              = $clog2(VERTICAL_WIDTH)
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic [SXW-1:0] i_sx,
    input  logic [SYW-1:0] i_sy,
    input  logic           i_de,
    input  logic           i_wr_valid,
    input  logic [CW-1:0]  i_wr_char,
    output logic           o_wr_ready,
    input  logic           i_clear,
    output logic           o_busy,
    output logic [CW-1:0]  o_character,
    output logic [SXW-1:0] o_x,
    output logic [SYW-1:0] o_y,
    output logic [SXW-1:0] o_sx,
    output logic [SYW-1:0] o_sy,
    output logic           o_en
);

    localparam int COLS   = ACTIVE_H_PIXELS / CHAR_W;
    localparam int ROWS   = ACTIVE_LINES / CHAR_H;
    localparam int CELLS  = COLS * ROWS;
    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int ADDR_W = $clog2(CELLS);
    localparam int XSH    = $clog2(CHAR_W);
    localparam int YSH    = $clog2(CHAR_H);

    localparam logic [CW-1:0] CODE_CR = CW'(8'h0D);
    localparam logic [CW-1:0] CODE_LF = CW'(8'h0A);
    localparam logic [CW-1:0] BLANK   = CW'(BLANK_CHAR);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] clr_addr, clr_addr_n;
    logic [COL_W-1:0]  cur_col, cur_col_n;
    logic [ROW_W-1:0]  cur_row, cur_row_n;
    logic [ADDR_W-1:0] cur_addr;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [CW-1:0]     wr_data;

    logic [COL_W-1:0]  rd_col;
    logic [ROW_W-1:0]  rd_row;
    logic [ADDR_W-1:0] rd_addr;
    logic [CW-1:0]     rd_data;

    logic [CW-1:0]     mem [CELLS];

    logic              en_q;
    logic [SXW-1:0]    x_q, sx_q;
    logic [SYW-1:0]    y_q, sy_q;

    logic              accept;

    // ---------------- read path ----------------
    assign rd_col  = COL_W'(i_sx >> XSH);
    assign rd_row  = ROW_W'(i_sy >> YSH);
    assign rd_addr = i_de ? ADDR_W'(ADDR_W'(rd_row) * ADDR_W'(COLS) + ADDR_W'(rd_col)) : '0;

    // Unreset storage and read register so the array maps onto block RAM;
    // non-blocking write gives read-old-value on a same-address collision.
    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            en_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
            sx_q <= '0;
            sy_q <= '0;
        end else begin
            en_q <= i_de;
            x_q  <= i_de ? (i_sx & ~SXW'(CHAR_W - 1)) : '0;
            y_q  <= i_de ? (i_sy & ~SYW'(CHAR_H - 1)) : '0;
            sx_q <= i_sx;
            sy_q <= i_sy;
        end
    end

    assign o_character = en_q ? rd_data : '0;
    assign o_x         = x_q;
    assign o_y         = y_q;
    assign o_sx        = sx_q;
    assign o_sy        = sy_q;
    assign o_en        = en_q;

    // ---------------- write side / FSM ----------------
    assign o_wr_ready = (state == S_IDLE) && !i_clear;
    assign o_busy     = (state == S_CLEAR) && !i_reset;
    assign accept     = i_wr_valid && o_wr_ready;
    assign cur_addr   = ADDR_W'(ADDR_W'(cur_row) * ADDR_W'(COLS) + ADDR_W'(cur_col));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
            cur_col  <= '0;
            cur_row  <= '0;
        end else begin
            state    <= state_n;
            clr_addr <= clr_addr_n;
            cur_col  <= cur_col_n;
            cur_row  <= cur_row_n;
        end
    end

    always_comb begin
        state_n    = state;
        clr_addr_n = clr_addr;
        cur_col_n  = cur_col;
        cur_row_n  = cur_row;
        wr_en      = 1'b0;
        wr_addr    = clr_addr;
        wr_data    = BLANK;
        case (state)
            S_CLEAR: begin
                wr_en = 1'b1;
                if (clr_addr == ADDR_W'(CELLS - 1)) begin
                    state_n    = S_IDLE;
                    clr_addr_n = '0;
                    cur_col_n  = '0;
                    cur_row_n  = '0;
                end else begin
                    clr_addr_n = clr_addr + ADDR_W'(1);
                end
            end
            S_IDLE: begin
                if (i_clear) begin
                    state_n    = S_CLEAR;
                    clr_addr_n = '0;
                end else if (accept) begin
                    if (i_wr_char == CODE_CR) begin
                        cur_col_n = '0;
                    end else if (i_wr_char == CODE_LF) begin
                        cur_col_n = '0;
                        cur_row_n = (cur_row == ROW_W'(ROWS - 1)) ? '0 : cur_row + ROW_W'(1);
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = cur_addr;
                        wr_data = i_wr_char;
                        if (cur_col == COL_W'(COLS - 1)) begin
                            cur_col_n = '0;
                            cur_row_n = (cur_row == ROW_W'(ROWS - 1)) ? '0 : cur_row + ROW_W'(1);
                        end else begin
                            cur_col_n = cur_col + COL_W'(1);
                        end
                    end
                end
            end
            default: state_n = S_CLEAR;
        endcase
    end

endmodule
